// File: rtl/vga_rect_master.sv
// Rectangle filler: accepts a corner-pair command, clips it to the screen and
// streams one Avalon-MM pixel write per point in row-major order.
module vga_rect_master #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_x0_i,
  input  logic [7:0]  cmd_x1_i,
  input  logic [6:0]  cmd_y0_i,
  input  logic [6:0]  cmd_y1_i,
  input  logic [2:0]  cmd_colour_i,
  output logic [3:0]  m_address_o,
  output logic        m_write_o,
  output logic [31:0] m_writedata_o,
  input  logic        m_waitrequest_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [14:0] pix_count_o
);

  localparam logic [7:0] XMax = 8'(WIDTH - 1);
  localparam logic [6:0] YMax = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x0_q, x0_d, x1_q, x1_d;
  logic [6:0]  y0_q, y0_d, y1_q, y1_d;
  logic [2:0]  colour_q, colour_d;
  logic [7:0]  xa_q, xa_d, xb_q, xb_d, x_q, x_d;
  logic [6:0]  yb_q, yb_d, y_q, y_d;
  logic [14:0] pix_q, pix_d;

  // Normalised corners, evaluated from the captured command during SETUP.
  logic [7:0] xa_s, xb_s;
  logic [6:0] ya_s, yb_s;

  always_comb begin
    xa_s = (x0_q < x1_q) ? x0_q : x1_q;
    xb_s = (x0_q < x1_q) ? x1_q : x0_q;
    ya_s = (y0_q < y1_q) ? y0_q : y1_q;
    yb_s = (y0_q < y1_q) ? y1_q : y0_q;
    if (xb_s > XMax) xb_s = XMax;
    if (yb_s > YMax) yb_s = YMax;
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    colour_d = colour_q;
    xa_d     = xa_q;
    xb_d     = xb_q;
    yb_d     = yb_q;
    x_d      = x_q;
    y_d      = y_q;
    pix_d    = pix_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          x0_d     = cmd_x0_i;
          x1_d     = cmd_x1_i;
          y0_d     = cmd_y0_i;
          y1_d     = cmd_y1_i;
          colour_d = cmd_colour_i;
          pix_d    = '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (xa_s > XMax || ya_s > YMax) begin
          state_d = StDone;
        end else begin
          xa_d    = xa_s;
          xb_d    = xb_s;
          yb_d    = yb_s;
          x_d     = xa_s;
          y_d     = ya_s;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!m_waitrequest_i) begin
          pix_d = pix_q + 15'd1;
          if (x_q == xb_q) begin
            if (y_q == yb_q) begin
              state_d = StDone;
            end else begin
              x_d = xa_q;
              y_d = y_q + 7'd1;
            end
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
      xa_q     <= '0;
      xb_q     <= '0;
      yb_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      colour_q <= colour_d;
      xa_q     <= xa_d;
      xb_q     <= xb_d;
      yb_q     <= yb_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_q    <= pix_d;
    end
  end

  // The pixel word is built from registers that only move on a completed
  // write, so it stays stable through waitrequest stalls.
  assign m_writedata_o = {13'b0, colour_q, x_q, 1'b0, y_q};
  assign m_address_o   = 4'b0000;
  assign m_write_o     = (state_q == StWrite);
  assign cmd_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign pix_count_o   = pix_q;

endmodule

// File: tb/tb_vga_rect_master.sv
// Scoreboard bench for vga_rect_master: the rectangle model pushes expected
// pixel words, a forked monitor pops and compares them as writes complete.
module tb_vga_rect_master;

  logic        clk = 1'b0;
  logic        reset_i, cmd_valid_i, m_waitrequest_i;
  logic [7:0]  cmd_x0_i, cmd_x1_i;
  logic [6:0]  cmd_y0_i, cmd_y1_i;
  logic [2:0]  cmd_colour_i;
  logic        cmd_ready_o, m_write_o, busy_o, done_o;
  logic [3:0]  m_address_o;
  logic [31:0] m_writedata_o;
  logic [14:0] pix_count_o;

  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  int          cnt100 = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  vga_rect_master #(.WIDTH(160), .HEIGHT(120)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i(cmd_x0_i), .cmd_x1_i(cmd_x1_i),
    .cmd_y0_i(cmd_y0_i), .cmd_y1_i(cmd_y1_i), .cmd_colour_i(cmd_colour_i),
    .m_address_o(m_address_o), .m_write_o(m_write_o),
    .m_writedata_o(m_writedata_o), .m_waitrequest_i(m_waitrequest_i),
    .busy_o(busy_o), .done_o(done_o), .pix_count_o(pix_count_o)
  );

  function automatic int push_rect(int x0, int y0, int x1, int y1, int col);
    int xa, xb, ya, yb, n;
    xa = (x0 < x1) ? x0 : x1;
    xb = (x0 < x1) ? x1 : x0;
    ya = (y0 < y1) ? y0 : y1;
    yb = (y0 < y1) ? y1 : y0;
    if (xb > 159) xb = 159;
    if (yb > 119) yb = 119;
    n = 0;
    if (xa <= 159 && ya <= 119)
      for (int y = ya; y <= yb; y++)
        for (int x = xa; x <= xb; x++) begin
          exp_q.push_back(32'((col << 16) | (x << 8) | y));
          n++;
        end
    return n;
  endfunction

  task automatic monitor();
    logic [31:0] prev_d = '0;
    logic [31:0] e;
    logic        prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (m_write_o) begin
        total++;
        if (m_address_o !== 4'b0000) begin
          bad++;
          $display("FAIL address: got %h want 0", m_address_o);
        end
        if (prev_stall) begin
          total++;
          if (m_writedata_o !== prev_d) begin
            bad++;
            $display("FAIL stall_hold: got %h want %h", m_writedata_o, prev_d);
          end
        end
        if (m_writedata_o === 32'h0000_0100) cnt100++;
        if (!m_waitrequest_i) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got %h want none", m_writedata_o);
          end else begin
            e = exp_q.pop_front();
            pops++;
            if (m_writedata_o !== e) begin
              bad++;
              $display("FAIL pixel_word: got %h want %h", m_writedata_o, e);
            end
          end
        end
        prev_stall = m_waitrequest_i;
        prev_d     = m_writedata_o;
      end else begin
        prev_stall = 1'b0;
      end
    end
  endtask

  // Drives a command at posedge+1 and returns just after the accepting edge.
  task automatic send_cmd(int x0, int y0, int x1, int y1, int col);
    int n;
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_cmd: got %b want 1", cmd_ready_o);
    end
    cmd_x0_i = 8'(x0); cmd_y0_i = 7'(y0);
    cmd_x1_i = 8'(x1); cmd_y1_i = 7'(y1);
    cmd_colour_i = 3'(col);
    cmd_valid_i = 1'b1;
    n = push_rect(x0, y0, x1, y1, col);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    total++;
    if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0 || m_write_o !== 1'b0) begin
      bad++;
      $display("FAIL accept_state: got busy=%b ready=%b wr=%b want 1 0 0",
               busy_o, cmd_ready_o, m_write_o);
    end
  endtask

  task automatic wait_done(int want_pix);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_o) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: got no done want done");
    end else begin
      total++;
      if (busy_o !== 1'b1 || m_write_o !== 1'b0) begin
        bad++;
        $display("FAIL done_cycle: got busy=%b wr=%b want 1 0", busy_o, m_write_o);
      end
      @(posedge clk); #1;
      total++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL done_width: got done=%b busy=%b ready=%b want 0 0 1",
                 done_o, busy_o, cmd_ready_o);
      end
    end
    total++;
    if (pix_count_o !== 15'(want_pix)) begin
      bad++;
      $display("FAIL pix_count: got %0d want %0d", pix_count_o, want_pix);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    total++;
    if (m_write_o !== 0 || busy_o !== 0 || done_o !== 0 || pix_count_o !== 0 ||
        m_writedata_o !== 0 || m_address_o !== 0) begin
      bad++;
      $display("FAIL reset_initial: got wr=%b busy=%b done=%b pix=%0d data=%h want all 0",
               m_write_o, busy_o, done_o, pix_count_o, m_writedata_o);
    end
    @(negedge clk); reset_i = 1'b0;
    @(posedge clk); #1;
    send_cmd(0, 0, 1, 0, 7);
    wait_done(2);
    // Mid-cycle reset with non-zero state: outputs must clear without an edge.
    @(negedge clk); #2;
    reset_i = 1'b1;
    #1;
    total++;
    if (m_write_o !== 0 || busy_o !== 0 || done_o !== 0 || pix_count_o !== 0 ||
        m_writedata_o !== 0) begin
      bad++;
      $display("FAIL reset_async: got wr=%b busy=%b done=%b pix=%0d data=%h want all 0",
               m_write_o, busy_o, done_o, pix_count_o, m_writedata_o);
    end
    @(negedge clk); reset_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready_o);
    end
  endtask

  task automatic test_single_pixel();
    send_cmd(5, 3, 5, 3, 5);
    @(posedge clk); #1;
    total++;
    if (m_write_o !== 1'b1 || m_writedata_o !== 32'h0005_0503) begin
      bad++;
      $display("FAIL single_latency: got wr=%b data=%h want 1 00050503",
               m_write_o, m_writedata_o);
    end
    wait_done(1);
  endtask

  task automatic test_reversed_and_ignore();
    send_cmd(2, 1, 0, 0, 1);
    // A second command held during the fill must be dropped.
    cmd_x0_i = 8'd50; cmd_x1_i = 8'd60; cmd_y0_i = 7'd50; cmd_y1_i = 7'd60;
    cmd_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    wait_done(6);
  endtask

  task automatic test_stall();
    int c0;
    c0 = cnt100;
    send_cmd(0, 0, 3, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_waitrequest_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 m_waitrequest_i = 1'b0;
    wait_done(4);
    total++;
    if (cnt100 - c0 != 4) begin
      bad++;
      $display("FAIL stall_cycles: got %0d want 4", cnt100 - c0);
    end
  endtask

  task automatic test_clip();
    send_cmd(158, 118, 200, 127, 2);
    wait_done(4);
    send_cmd(170, 5, 180, 6, 6);
    wait_done(0);
  endtask

  task automatic test_reset_mid_fill();
    int p0;
    bit ok = 0;
    p0 = pops;
    send_cmd(0, 0, 9, 9, 4);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pops - p0 == 3) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midfill_timeout: got %0d writes want 3", pops - p0);
    end
    @(posedge clk); #1;
    reset_i = 1'b1;
    #1;
    total++;
    if (m_write_o !== 1'b0 || pix_count_o !== 0) begin
      bad++;
      $display("FAIL midfill_reset: got wr=%b pix=%0d want 0 0", m_write_o, pix_count_o);
    end
    exp_q.delete();
    @(negedge clk); reset_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (busy_o !== 1'b0 || m_write_o !== 1'b0) begin
      bad++;
      $display("FAIL midfill_idle: got busy=%b wr=%b want 0 0", busy_o, m_write_o);
    end
    send_cmd(1, 1, 1, 1, 3);
    wait_done(1);
  endtask

  initial begin
    reset_i = 1'b1;
    cmd_valid_i = 1'b0;
    m_waitrequest_i = 1'b0;
    cmd_x0_i = '0; cmd_x1_i = '0; cmd_y0_i = '0; cmd_y1_i = '0; cmd_colour_i = '0;
    fork
      monitor();
    join_none
    #12;
    test_reset();
    test_single_pixel();
    test_reversed_and_ignore();
    test_stall();
    test_clip();
    test_reset_mid_fill();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
